// File: rtl/dir_pulse_gen.sv
// dir_pulse_gen
// Turns four raw push-buttons into one-cycle, one-hot direction pulses for the
// cursor mover. Each button is synchronised and debounced. A single held
// button gives one pulse on press and then auto-repeats. Multi-button
// chords never produce a pulse.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - synchronous, active-high reset
//   btn_raw    - asynchronous buttons {right, left, down, up}, active-high
//   directions - registered one-hot pulse (one cycle) or 4'b0000
//   pressed    - registered debounced button vector
module dir_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 40000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter bit          ENABLE_REPEAT   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] directions,
  output logic [3:0] pressed
);

  // Counter widths hold each parameter's full value, so nothing can wrap.
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = $clog2(RP_MAX + 1);

  // The debounce counter fires on the edge it would reach DEBOUNCE_CYCLES,
  // i.e. when it already holds DEBOUNCE_CYCLES-1.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // The repeat counter is loaded with N-1 and the pulse is emitted on the
  // edge where it reads zero, which places the pulse exactly N edges after
  // the previous one.
  localparam logic [RP_W-1:0] DELAY_LD  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LD = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [RP_W-1:0] RP_ONE    = RP_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  logic [3:0]      sync1_q;
  logic [3:0]      sync2_q;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];
  logic [3:0]      pressed_q;
  logic [3:0]      pressed_d;
  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [3:0]      held_q;
  logic [3:0]      held_d;
  logic [RP_W-1:0] rep_cnt_q;
  logic [RP_W-1:0] rep_cnt_d;
  logic [3:0]      dir_q;
  logic [3:0]      dir_d;
  logic            change_now_s;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count consecutive disagreeing edges, accept the new
  // level once the run is long enough, restart on any agreement.
  always_comb begin
    pressed_d = pressed_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != pressed_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          pressed_d[i] = sync2_q[i];
          db_cnt_d[i]  = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pressed_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      pressed_q <= pressed_d;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Command FSM next-state logic. held_q remembers the direction being
  // repeated so any change of pressed_q is seen as an abort. A repeat that
  // lands on the same edge the debounced vector changes is dropped, so a
  // release never yields a stale pulse.
  always_comb begin
    state_d      = state_q;
    held_d       = held_q;
    rep_cnt_d    = rep_cnt_q;
    dir_d        = 4'b0000;
    change_now_s = (pressed_d != pressed_q);
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(pressed_q)) begin
          dir_d     = pressed_q;
          held_d    = pressed_q;
          rep_cnt_d = DELAY_LD;
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (pressed_q != held_q) begin
          if (is_onehot(pressed_q)) begin
            dir_d     = pressed_q;
            held_d    = pressed_q;
            rep_cnt_d = DELAY_LD;
            state_d   = ST_HOLD;
          end else begin
            held_d  = 4'b0000;
            state_d = ST_WAIT;
          end
        end else if (rep_cnt_q == '0) begin
          if (ENABLE_REPEAT && !change_now_s) begin
            dir_d     = held_q;
            rep_cnt_d = PERIOD_LD;
          end else begin
            rep_cnt_d = '0;
          end
        end else begin
          rep_cnt_d = rep_cnt_q - RP_ONE;
        end
      end
      ST_WAIT: begin
        if (pressed_q == 4'b0000) begin
          state_d = ST_IDLE;
        end else if (is_onehot(pressed_q)) begin
          dir_d     = pressed_q;
          held_d    = pressed_q;
          rep_cnt_d = DELAY_LD;
          state_d   = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        held_d    = 4'b0000;
        rep_cnt_d = '0;
      end
    endcase
  end

  // Command FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      held_q    <= 4'b0000;
      rep_cnt_q <= '0;
      dir_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      rep_cnt_q <= rep_cnt_d;
      dir_q     <= dir_d;
    end
  end

  assign directions = dir_q;
  assign pressed    = pressed_q;

endmodule
